pipe_stage_hs: RTL
==================

Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- A chain of STAGES register slices carries a data field and a control field, with valid/ready handshake, synchronous flush and bubble insertion.
- Lets stages stall independently. A taken branch or jump kills younger instructions by flushing.
- Control bits of an empty slot read as a safe no-op value (no reg_write or mem_write).

Parameters:
- DATA_W, 32, width of payload field (operands, PC+4, ALU result, branch target, ...)
- CTRL_W, 8, width of control field (reg_write, mem_read, mem_write, mem_to_reg, access size, ...)
- STAGES, 1, number of register slices in series (>=1)
- CTRL_RST, {CTRL_W{1'b0}}, control value presented on reset and whenever out_valid=0 (e.g. access size field = 2'b10)

Ports:
- clk, input, 1, rising-edge clock
- reset_n, input, 1, reset; asynchronous assert, active-low
- flush, input, 1, synchronous kill of all in-flight entries
- in_valid, input, 1, upstream has an entry
- in_ready, output, 1, block accepts the entry this cycle
- in_ctrl, input, CTRL_W, upstream control field
- in_data, input, DATA_W, upstream payload
- out_valid, output, 1, head entry valid
- out_ready, input, 1, downstream consumes head this cycle
- out_ctrl, output, CTRL_W, head control; equals CTRL_RST when out_valid=0
- out_data, output, DATA_W, head payload
- occupancy, output, $clog2(2*STAGES+1), number of valid entries held

Behaviour:
- Reset (reset_n=0, asynchronous): all valids 0, all data regs 0, all ctrl regs CTRL_RST, occupancy 0. Outputs are therefore out_valid=0, out_ctrl=CTRL_RST, out_data=0. in_ready is 0 while reset_n=0, and 1 on the first cycle after release.
- Transfer rules: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Slice i loads from slice i-1 when its own slot is empty or its content leaves this cycle (base mode, no skid).
- Base-mode ready is combinational: ready_i = !valid_i | ready_(i+1), and ready_STAGES = out_ready.
- Latency with no backpressure: an entry accepted at edge N appears at out_* after edge N+STAGES-1, i.e. STAGES cycles.
- Throughput: one entry per cycle sustained.
- Stall (out_valid=1, out_ready=0): the head is held. out_valid, out_ctrl and out_data stay stable until consumed. Upstream slices fill, then in_ready drops.
- Data regs load only on a transfer into the slice; otherwise they retain their value (no toggling on bubbles).
- The ctrl output mux forces CTRL_RST when the slot is invalid.
- flush=1: in_ready is forced to 0 and in_valid is ignored. At the next edge every valid clears and occupancy becomes 0. Flush has priority over out_ready; a head transfer in the flush cycle still counts downstream.
- Simultaneous accept and emit: occupancy is unchanged.
- occupancy is registered and updated by +1 on accept, -1 on emit, 0 on flush.
- occupancy never exceeds STAGES in base mode, or 2*STAGES with skid.
- Reset mid-stall or mid-flush: immediate return to reset state; no partial entries survive.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: each slice gains a one-entry skid buffer. in_ready and every inter-slice ready are driven directly from flops (ready_i = !skid_valid_i), breaking the combinational ready path.
- A slice that is accepting when downstream stalls parks the entry in skid. The skid drains first (order preserved) when downstream frees.
- Capacity is 2*STAGES. Latency with no backpressure is unchanged (STAGES). Flush also clears skids.
- Undefined: base mode as above, with combinational ready, capacity STAGES and no skid registers.

Test Plan:
- STAGES=1, stream in_data 0x1,0x2,0x3 with out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, one cycle after each accept; occupancy stays 1.
- STAGES=2, accept 0xA0 then hold out_ready=0 for 4 cycles with in_valid=1 (0xA1,0xA2,...) -> out_data=0xA0 stable; in_ready drops after occupancy=2 (4 with skid); on out_ready=1 order is 0xA0,0xA1,0xA2...
- CTRL_RST=8'h02, idle input -> out_valid=0, out_ctrl=8'h02 while data regs hold the last value; reset_n=0 -> out_data=0 immediately, asynchronous to clk.
- STAGES=3 full, assert flush with in_valid=1, in_data=0xDEAD -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; 0xDEAD never appears at the output.
- Random in_valid/out_ready (10k cycles, both modes) -> scoreboard shows in-order, no loss/duplication; occupancy matches the model; out_* stable during stalls.
- PIPE_STAGE_SKID_EN defined -> formal/lint check finds no combinational path from out_ready to in_ready.

Source files
------------

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Parametrised inter-stage pipeline register chain. STAGES register
//            slices carry a payload field and a control field under a
//            valid/ready handshake, with synchronous flush. The control
//            output reads CTRL_RST whenever the head slot is empty.
//            Optional build macro PIPE_STAGE_SKID_EN adds a one-entry skid
//            buffer per slice so that every ready is driven from a flop.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            flush      - synchronous kill of all in-flight entries
//            in_valid   - upstream offers an entry
//            in_ready   - entry accepted this cycle (when in_valid)
//            in_ctrl    - upstream control field   [CTRL_W]
//            in_data    - upstream payload          [DATA_W]
//            out_valid  - head entry valid
//            out_ready  - downstream consumes head this cycle
//            out_ctrl   - head control, CTRL_RST when out_valid=0
//            out_data   - head payload
//            occupancy  - number of valid entries held
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 8,
    parameter int                STAGES   = 1,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CTRL_W-1:0]                   in_ctrl,
    input  logic [DATA_W-1:0]                   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CTRL_W-1:0]                   out_ctrl,
    output logic [DATA_W-1:0]                   out_data,
    output logic [$clog2(2*STAGES+1)-1:0]       occupancy
);

    localparam int                 c_OCC_W   = $clog2(2*STAGES+1);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

    // w_ready[i]: slice i can take an entry this cycle; w_ready[STAGES] is
    // the downstream consumer.
    logic [STAGES:0]    w_ready;
    logic [STAGES-1:0]  w_valid;
    logic [DATA_W-1:0]  w_data [STAGES];
    logic [CTRL_W-1:0]  w_ctrl [STAGES];
    logic               w_accept;
    logic               w_emit;
    logic [c_OCC_W-1:0] r_occ;

`ifdef PIPE_STAGE_SKID_EN
    logic [STAGES-1:0]  w_skid_full;

    // Every ready comes straight from a skid flag, so out_ready never
    // reaches in_ready combinationally.
    always_comb begin
        w_ready[STAGES] = out_ready;
        for (int k = 0; k < STAGES; k++) begin
            w_ready[k] = ~w_skid_full[k];
        end
    end
`else
    // Ripple from the head backwards: a slice is free if empty or if its
    // occupant moves on this cycle.
    always_comb begin
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = ~w_valid[k] | w_ready[k+1];
        end
    end
`endif

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_slice
            logic              w_up_valid;
            logic [DATA_W-1:0] w_up_data;
            logic [CTRL_W-1:0] w_up_ctrl;
            logic              w_take;
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic [CTRL_W-1:0] r_ctrl;

            if (i == 0) begin : g_from_input
                assign w_up_valid = in_valid;
                assign w_up_data  = in_data;
                assign w_up_ctrl  = in_ctrl;
            end else begin : g_from_prev
                assign w_up_valid = w_valid[i-1];
                assign w_up_data  = w_data[i-1];
                assign w_up_ctrl  = w_ctrl[i-1];
            end

            // A real transfer into this slice; nothing moves during flush.
            assign w_take = w_up_valid & w_ready[i] & ~flush;

`ifdef PIPE_STAGE_SKID_EN
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            assign w_skid_full[i] = r_skid_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid      <= 1'b0;
                    r_data       <= '0;
                    r_ctrl       <= CTRL_RST;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= CTRL_RST;
                end else if (flush) begin
                    r_valid      <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (!r_valid || w_ready[i+1]) begin
                    // Main slot free or leaving: the parked entry is older
                    // than anything upstream, so it goes first.
                    if (r_skid_valid) begin
                        r_valid      <= 1'b1;
                        r_data       <= r_skid_data;
                        r_ctrl       <= r_skid_ctrl;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_valid <= w_take;
                        if (w_take) begin
                            r_data <= w_up_data;
                            r_ctrl <= w_up_ctrl;
                        end
                    end
                end else if (w_take) begin
                    // Downstream stalled while we were still accepting.
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_up_data;
                    r_skid_ctrl  <= w_up_ctrl;
                end
            end
`else
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_ctrl  <= CTRL_RST;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_ready[i]) begin
                    r_valid <= w_take;
                    if (w_take) begin
                        r_data <= w_up_data;
                        r_ctrl <= w_up_ctrl;
                    end
                end
            end
`endif

            assign w_valid[i] = r_valid;
            assign w_data[i]  = r_data;
            assign w_ctrl[i]  = r_ctrl;
        end
    endgenerate

    assign in_ready  = reset_n & ~flush & w_ready[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1];
    // An empty head must never look like a register or memory write.
    assign out_ctrl  = out_valid ? w_ctrl[STAGES-1] : CTRL_RST;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_accept && !w_emit) begin
            r_occ <= r_occ + c_OCC_ONE;
        end else if (!w_accept && w_emit) begin
            r_occ <= r_occ - c_OCC_ONE;
        end
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire
